// File: rtl/i_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   state_t        : loader FSM states (IDLE, RECV, WRITE, DONE)
//   BYTE_W         : width of one stream byte
//   BYTES_PER_WORD : stream bytes assembled into one instruction word
//   is_last_byte() : true when a byte counter value marks the final byte of a word
package i_mem_loader_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_W         = BYTE_W * BYTES_PER_WORD;
  localparam int unsigned BCNT_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic is_last_byte(input logic [BCNT_W-1:0] cnt);
    return cnt == BCNT_W'(BYTES_PER_WORD - 1);
  endfunction

endpackage

// File: rtl/i_mem_loader_if.sv
// Bus bundle between a host (byte stream source / loader control) and the
// instruction-memory loader, including the memory write port and status.
//   start, n_words          : load request and word count
//   in_valid, in_data       : byte stream, in_ready returned by the loader
//   wr_en, wr_addr, wr_data : single-cycle instruction memory write port
//   cpu_hold, done, error   : loader status
// modport master : host side (drives request and stream)
// modport slave  : loader side
interface i_mem_loader_if
  import i_mem_loader_pkg::*;
#(
  parameter int tamanho       = 32,
  parameter int enderecamento = 10
);

  logic                   start;
  logic [enderecamento:0] n_words;
  logic                   in_valid;
  logic [BYTE_W-1:0]      in_data;
  logic                   in_ready;
  logic                   wr_en;
  logic [tamanho-1:0]     wr_addr;
  logic [tamanho-1:0]     wr_data;
  logic                   cpu_hold;
  logic                   done;
  logic                   error;

  modport master (
    output start, n_words, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
  );

  modport slave (
    input  start, n_words, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
  );

endinterface

// File: rtl/i_mem_loader_word_assembler.sv
// Collects stream bytes (most significant first) into 32-bit words.
//   clk, rst   : clock and synchronous active-high reset
//   clear      : synchronous restart of the byte position (new load)
//   byte_valid : a byte is transferred this cycle
//   byte_data  : the transferred byte
//   word_ready : this transfer completes a word (combinational pulse)
//   word       : the completed word, valid while word_ready is high
module i_mem_loader_word_assembler
  import i_mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              word_ready,
  output logic [WORD_W-1:0] word
);

  // Only the three earlier bytes of a word need to be held; the fourth is
  // taken straight from the input so the word is available on the same
  // cycle as its last transfer, which keeps the write one cycle later.
  logic [WORD_W-BYTE_W-1:0] shift;
  logic [BCNT_W-1:0]        byte_cnt;

  assign word_ready = byte_valid && is_last_byte(byte_cnt);
  assign word       = {shift, byte_data};

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shift    <= '0;
      byte_cnt <= '0;
    end else if (byte_valid) begin
      shift    <= {shift[WORD_W-2*BYTE_W-1:0], byte_data};
      byte_cnt <= byte_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i_mem_loader.sv
// Instruction memory loader: receives a byte stream, assembles big-endian
// words and writes them at consecutive word-aligned byte addresses from 0,
// holding the processor in reset while the load is in progress.
//   clock : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : i_mem_loader_if slave port
//           (start/n_words request, in_valid/in_data/in_ready stream,
//            wr_en/wr_addr/wr_data write port, cpu_hold/done/error status)
// Parameters: tamanho (write port width), enderecamento (word-address bits),
//             PALAVRAS (maximum words written per load).
module i_mem_loader
  import i_mem_loader_pkg::*;
#(
  parameter int tamanho       = 32,
  parameter int enderecamento = 10,
  parameter int PALAVRAS      = 64
)(
  input  logic           clock,
  input  logic           reset,
  i_mem_loader_if.slave  bus
);

  typedef logic [enderecamento:0] cnt_t;
  typedef logic [tamanho-1:0]     word_t;

  localparam cnt_t MAX_WORDS = cnt_t'(PALAVRAS);

  state_t      state;
  cnt_t        n_eff;
  cnt_t        word_idx;
  cnt_t        n_clamped;
  cnt_t        next_idx;
  logic        start_ok;
  logic        xfer;
  logic        word_ready;
  logic [WORD_W-1:0] word;

  logic        wr_en_r;
  word_t       wr_addr_r;
  word_t       wr_data_r;
  logic        cpu_hold_r;
  logic        done_r;
  logic        error_r;

  assign n_clamped = (bus.n_words > MAX_WORDS) ? MAX_WORDS : bus.n_words;
  assign next_idx  = word_idx + 1'b1;
  assign start_ok  = bus.start && (state == IDLE || state == DONE);
  assign xfer      = bus.in_valid && bus.in_ready;

  i_mem_loader_word_assembler u_asm (
    .clk        (clock),
    .rst        (reset),
    .clear      (start_ok),
    .byte_valid (xfer),
    .byte_data  (bus.in_data),
    .word_ready (word_ready),
    .word       (word)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      n_eff      <= '0;
      word_idx   <= '0;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= '0;
      wr_data_r  <= '0;
      cpu_hold_r <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      wr_en_r <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            n_eff    <= n_clamped;
            error_r  <= (bus.n_words > MAX_WORDS);
            word_idx <= '0;
            if (n_clamped == '0) begin
              state      <= DONE;
              done_r     <= 1'b1;
              cpu_hold_r <= 1'b0;
            end else begin
              state      <= RECV;
              done_r     <= 1'b0;
              cpu_hold_r <= 1'b1;
            end
          end
        end
        RECV: begin
          // The write strobe and its address/data are registered on the
          // edge that accepts the final byte, so they are valid in WRITE.
          if (word_ready) begin
            state     <= WRITE;
            wr_en_r   <= 1'b1;
            wr_addr_r <= word_t'({word_idx, 2'b00});
            wr_data_r <= word_t'(word);
          end
        end
        WRITE: begin
          word_idx <= next_idx;
          if (next_idx == n_eff) begin
            state      <= DONE;
            done_r     <= 1'b1;
            cpu_hold_r <= 1'b0;
          end else begin
            state <= RECV;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready = (state == RECV);
  assign bus.wr_en    = wr_en_r;
  assign bus.wr_addr  = wr_addr_r;
  assign bus.wr_data  = wr_data_r;
  assign bus.cpu_hold = cpu_hold_r;
  assign bus.done     = done_r;
  assign bus.error    = error_r;

endmodule

// File: tb/tb_i_mem_loader.sv
// Scoreboard bench for i_mem_loader: expected writes are queued as stimulus
// is issued, and a monitor compares every wr_en cycle against the queue.
module tb_i_mem_loader;
  import i_mem_loader_pkg::*;

  localparam int TAM = 32;
  localparam int ENDR = 10;
  localparam int PAL = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;

  i_mem_loader_if #(.tamanho(TAM), .enderecamento(ENDR)) bus ();

  i_mem_loader #(.tamanho(TAM), .enderecamento(ENDR), .PALAVRAS(PAL)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next queued expectation.
  always @(negedge clock) begin
    if (bus.wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                 bus.wr_addr, bus.wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 64'(bus.wr_addr), 64'(mon_e.addr));
        chk("wr_data", 64'(bus.wr_data), 64'(mon_e.data));
        chk("hold_at_write", 64'(bus.cpu_hold), 64'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int unsigned addr, input logic [31:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start(input int n);
    bus.start   = 1'b1;
    bus.n_words = 11'(n);
    tick();
    bus.start   = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int w;
    bus.in_valid = 1'b0;
    repeat (gap) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    if (w >= 50) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: got in_ready=%0b expected 1 within 50 cycles", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int c;
    c = 0;
    while (bus.done !== 1'b1 && c < budget) begin
      tick();
      c++;
    end
    chk(name, 64'(bus.done), 64'd1);
  endtask

  initial begin
    logic [31:0] w;
    bus.start    = 1'b0;
    bus.n_words  = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // 1: reset and idle
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("reset_outputs",
        64'({bus.wr_en, bus.wr_addr, bus.wr_data, bus.cpu_hold, bus.done, bus.error}), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd0);

    // 2: two words, continuous stream
    push(0, 32'h20080005);
    push(4, 32'h20090007);
    pulse_start(2);
    chk("t2_hold_start", 64'(bus.cpu_hold), 64'd1);
    send_word(32'h20080005, 0);
    send_word(32'h20090007, 0);
    wait_done("t2_done", 20);
    chk("t2_hold_end", 64'(bus.cpu_hold), 64'd0);
    chk("t2_error", 64'(bus.error), 64'd0);
    chk("t2_all_writes", 64'(exp_q.size()), 64'd0);

    // 3: same stream with gaps, extra byte offered in DONE
    push(0, 32'h20080005);
    push(4, 32'h20090007);
    pulse_start(2);
    chk("t3_done_cleared", 64'(bus.done), 64'd0);
    send_word(32'h20080005, 3);
    send_word(32'h20090007, 3);
    wait_done("t3_done", 20);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      chk("t3_no_accept_in_done", 64'(bus.in_ready), 64'd0);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("t3_all_writes", 64'(exp_q.size()), 64'd0);

    // 4: zero-length load
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_done_after_reset", 64'(bus.done), 64'd0);
    pulse_start(0);
    chk("t4_done", 64'(bus.done), 64'd1);
    chk("t4_hold", 64'(bus.cpu_hold), 64'd0);
    chk("t4_error", 64'(bus.error), 64'd0);
    tick();
    chk("t4_hold_later", 64'(bus.cpu_hold), 64'd0);

    // 5: oversize request is clamped to PALAVRAS words
    for (int i = 0; i < PAL; i++) begin
      w = {8'(i), 8'hA5, ~8'(i), 8'h3C};
      push(i * 4, w);
    end
    pulse_start(70);
    chk("t5_error", 64'(bus.error), 64'd1);
    chk("t5_hold", 64'(bus.cpu_hold), 64'd1);
    for (int i = 0; i < PAL; i++) begin
      w = {8'(i), 8'hA5, ~8'(i), 8'h3C};
      send_word(w, 0);
    end
    wait_done("t5_done", 20);
    chk("t5_all_writes", 64'(exp_q.size()), 64'd0);
    chk("t5_error_held", 64'(bus.error), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h11;
    repeat (8) tick();
    bus.in_valid = 1'b0;
    chk("t5_no_extra_ready", 64'(bus.in_ready), 64'd0);

    // 6: reset in the middle of a word, then a clean reload
    pulse_start(1);
    chk("t6_error_cleared", 64'(bus.error), 64'd0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_reset_hold", 64'(bus.cpu_hold), 64'd0);
    chk("t6_reset_ready", 64'(bus.in_ready), 64'd0);
    chk("t6_reset_done", 64'(bus.done), 64'd0);
    push(0, 32'h8C080000);
    pulse_start(1);
    send_word(32'h8C080000, 0);
    wait_done("t6_done", 20);
    repeat (3) tick();
    chk("t6_all_writes", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
